i2s_frame_feeder: RTL and testbench

I2S_FRAME_FEEDER -- requirements
Module: i2s_frame_feeder

---
 rtl/i2s_frame_feeder_if.sv | 33 +++
 rtl/i2s_frame_feeder.sv | 134 +++++++++++++
 tb/tb_i2s_frame_feeder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_frame_feeder_if.sv
// Handshake bundle for i2s_frame_feeder: upstream frame offer
// plus transmitter word request and returned word/underrun.
interface i2s_frame_feeder_if #(
  parameter int NUM_BITS = 24
);
  logic [NUM_BITS-1:0] sample_l;
  logic [NUM_BITS-1:0] sample_r;
  logic                sample_valid;
  logic                sample_ready;
  logic                tx_ready;
  logic [NUM_BITS-1:0] word_out;
  logic                underrun;

  modport master (
    output sample_l,
    output sample_r,
    output sample_valid,
    output tx_ready,
    input  sample_ready,
    input  word_out,
    input  underrun
  );

  modport slave (
    input  sample_l,
    input  sample_r,
    input  sample_valid,
    input  tx_ready,
    output sample_ready,
    output word_out,
    output underrun
  );
endinterface

// File: rtl/i2s_frame_feeder.sv
// Stereo frame FIFO feeding an I2S transmitter one word per tx_ready.
// Define I2S_FEEDER_UNDERRUN_CNT_EN to add a saturating underrun_count.
module i2s_frame_feeder #(
  parameter int NUM_BITS   = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef I2S_FEEDER_UNDERRUN_CNT_EN
  output logic [15:0] underrun_count,
`endif
  i2s_frame_feeder_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = 2 * NUM_BITS;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {
    PH_LEFT,
    PH_RIGHT
  } phase_e;

  logic [FW-1:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wptr_q;
  logic [AW-1:0]       rptr_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic                rdy_en_q;
  phase_e              phase_q;
  phase_e              phase_d;
  logic [NUM_BITS-1:0] head_q;
  logic [NUM_BITS-1:0] head_d;
  logic [NUM_BITS-1:0] word_q;
  logic [NUM_BITS-1:0] word_d;
  logic                und_q;
  logic                und_d;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic [FW-1:0]       rd_frame;

  assign full     = (cnt_q == DEPTH_C);
  assign empty    = (cnt_q == '0);
  assign rd_frame = mem_q[rptr_q];

  assign bus.sample_ready = rdy_en_q & ~full & ~rst;
  assign bus.word_out     = word_q;
  assign bus.underrun     = und_q;

  assign push = bus.sample_valid & bus.sample_ready;

  // Head keeps only the pending right word; the left one left on pop.
  always_comb begin
    phase_d = phase_q;
    head_d  = head_q;
    word_d  = word_q;
    und_d   = 1'b0;
    pop     = 1'b0;
    if (bus.tx_ready) begin
      unique case (phase_q)
        PH_LEFT: begin
          word_d  = head_q;
          phase_d = PH_RIGHT;
        end
        PH_RIGHT: begin
          phase_d = PH_LEFT;
          if (!empty) begin
            pop    = 1'b1;
            head_d = rd_frame[NUM_BITS-1:0];
            word_d = rd_frame[FW-1:NUM_BITS];
          end else begin
            head_d = '0;
            word_d = '0;
            und_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
      phase_q  <= PH_RIGHT;
      head_q   <= '0;
      word_q   <= '0;
      und_q    <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
      phase_q  <= phase_d;
      head_q   <= head_d;
      word_q   <= word_d;
      und_q    <= und_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {bus.sample_l, bus.sample_r};
  end

`ifdef I2S_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ucnt_q <= '0;
    end else if (und_d && ucnt_q != 16'hFFFF) begin
      ucnt_q <= ucnt_q + 16'd1;
    end
  end

  assign underrun_count = ucnt_q;
`endif

endmodule

// File: tb/tb_i2s_frame_feeder.sv
// Scoreboard bench for i2s_frame_feeder: directed cases
// followed by a random frame stream against random tx_ready.
module tb_i2s_frame_feeder;

  localparam int NB    = 24;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [NB-1:0] w;
    logic          u;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  i2s_frame_feeder_if #(.NUM_BITS(NB)) bus ();

`ifdef I2S_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif

  i2s_frame_feeder #(
    .NUM_BITS  (NB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef I2S_FEEDER_UNDERRUN_CNT_EN
    .underrun_count(underrun_count),
`endif
    .bus           (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference model state, advanced once per cycle at negedge
  logic [2*NB-1:0] mq[$];
  exp_t            sb[$];
  logic            m_right;
  logic            m_rdyen;
  logic [NB-1:0]   m_head;
  logic [NB-1:0]   m_last;
  int unsigned     m_ucnt;

  initial begin
    exp_t            e;
    logic [2*NB-1:0] f;
    logic            acc;
    m_right = 1'b1;
    m_rdyen = 1'b0;
    m_head  = '0;
    m_last  = '0;
    m_ucnt  = 0;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("word", 32'(bus.word_out), 32'(e.w));
        chk("underrun", 32'(bus.underrun), 32'(e.u));
        m_last = e.w;
      end else begin
        chk("word_hold", 32'(bus.word_out), 32'(m_last));
        chk("underrun_idle", 32'(bus.underrun), 32'd0);
      end
      chk("ready", 32'(bus.sample_ready),
          32'(!rst && m_rdyen && mq.size() < DEPTH));
`ifdef I2S_FEEDER_UNDERRUN_CNT_EN
      chk("ucnt", 32'(underrun_count), 32'(m_ucnt));
`endif
      if (rst) begin
        mq.delete();
        sb.delete();
        m_right = 1'b1;
        m_rdyen = 1'b0;
        m_head  = '0;
        m_last  = '0;
        m_ucnt  = 0;
      end else begin
        acc = bus.sample_valid && m_rdyen && mq.size() < DEPTH;
        if (bus.tx_ready) begin
          if (!m_right) begin
            e.w     = m_head;
            e.u     = 1'b0;
            m_right = 1'b1;
          end else if (mq.size() > 0) begin
            f       = mq.pop_front();
            m_head  = f[NB-1:0];
            e.w     = f[2*NB-1:NB];
            e.u     = 1'b0;
            m_right = 1'b0;
          end else begin
            m_head  = '0;
            e.w     = '0;
            e.u     = 1'b1;
            m_right = 1'b0;
            if (m_ucnt < 32'hFFFF) m_ucnt++;
          end
          sb.push_back(e);
        end
        if (acc) mq.push_back({bus.sample_l, bus.sample_r});
        m_rdyen = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tx();
    bus.tx_ready = 1'b1;
    step();
    bus.tx_ready = 1'b0;
  endtask

  task automatic push_frame(input logic [NB-1:0] l,
                            input logic [NB-1:0] r);
    bit done;
    done = 1'b0;
    bus.sample_l     = l;
    bus.sample_r     = r;
    bus.sample_valid = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = bus.sample_ready;
      step();
    end
    bus.sample_valid = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  bit prod_done;

  initial begin
    rst              = 1'b1;
    bus.sample_l     = '0;
    bus.sample_r     = '0;
    bus.sample_valid = 1'b0;
    bus.tx_ready     = 1'b0;
    prod_done        = 1'b0;
    repeat (3) step();
    chk("rst_word", 32'(bus.word_out), 32'd0);
    chk("rst_ready", 32'(bus.sample_ready), 32'd0);
    rst = 1'b0;
    step();
    chk("rel_ready", 32'(bus.sample_ready), 32'd1);

    push_frame(24'h111111, 24'h222222);
    pulse_tx();
    chk("basic_l", 32'(bus.word_out), 32'h111111);
    repeat (2) step();
    pulse_tx();
    chk("basic_r", 32'(bus.word_out), 32'h222222);
    chk("basic_und", 32'(bus.underrun), 32'd0);

    for (int i = 0; i < DEPTH; i++)
      push_frame(NB'(24'hA00000 + i), NB'(24'hB00000 + i));
    chk("full_ready", 32'(bus.sample_ready), 32'd0);
    fork
      push_frame(24'hC00005, 24'hD00005);
      begin
        repeat (3) step();
        pulse_tx();
      end
    join
    repeat (9) begin
      pulse_tx();
      step();
    end

    pulse_tx();
    chk("empty_word", 32'(bus.word_out), 32'd0);
    chk("empty_und", 32'(bus.underrun), 32'd1);
`ifdef I2S_FEEDER_UNDERRUN_CNT_EN
    chk("empty_ucnt", 32'(underrun_count), 32'd1);
`endif
    step();
    chk("und_once", 32'(bus.underrun), 32'd0);
    pulse_tx();
    chk("empty_word2", 32'(bus.word_out), 32'd0);
    chk("empty_und2", 32'(bus.underrun), 32'd0);

    bus.tx_ready = 1'b1;
    push_frame(24'h333333, 24'h444444);
    bus.tx_ready = 1'b0;
    chk("nobypass_und", 32'(bus.underrun), 32'd1);
    pulse_tx();
    pulse_tx();
    chk("late_l", 32'(bus.word_out), 32'h333333);
    pulse_tx();
    chk("late_r", 32'(bus.word_out), 32'h444444);

    for (int i = 0; i < 3; i++)
      push_frame(NB'(24'h500000 + i), NB'(24'h600000 + i));
    pulse_tx();
    step();
    rst = 1'b1;
    repeat (2) step();
    chk("midrst_word", 32'(bus.word_out), 32'd0);
    rst = 1'b0;
    step();
    pulse_tx();
    chk("postrst_und", 32'(bus.underrun), 32'd1);
    chk("postrst_word", 32'(bus.word_out), 32'd0);

    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) step();
          push_frame(NB'($urandom), NB'($urandom));
        end
        prod_done = 1'b1;
      end
      begin
        int guard;
        guard = 0;
        while (!(prod_done && mq.size() == 0 && m_right)
               && guard < 30000) begin
          if ($urandom_range(0, 2) == 0) pulse_tx();
          else step();
          step();
          guard++;
        end
        if (guard >= 30000) chk("drain_timeout", 32'd0, 32'd1);
      end
    join

    repeat (3) step();
    chk("final_fifo", 32'(mq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
